// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared constants, state encoding and control-word layout for the schedule controller
package sched_pkg;

    localparam int SEL_W  = 4;
    localparam int STEP_W = 2;
    localparam int N_ALU  = 4;
    localparam int N_EN   = 7;

    // Operand select codes seen by the datapath muxes
    localparam logic [SEL_W-1:0] SEL_I1   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_I2   = 4'd1;
    localparam logic [SEL_W-1:0] SEL_I3   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_I4   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_I5   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_I6   = 4'd5;
    localparam logic [SEL_W-1:0] SEL_I7   = 4'd6;
    localparam logic [SEL_W-1:0] SEL_I8   = 4'd7;
    localparam logic [SEL_W-1:0] SEL_R2   = 4'd8;
    localparam logic [SEL_W-1:0] SEL_R5   = 4'd9;
    localparam logic [SEL_W-1:0] SEL_R6   = 4'd10;
    localparam logic [SEL_W-1:0] SEL_R9   = 4'd11;
    localparam logic [SEL_W-1:0] SEL_R12  = 4'd12;
    localparam logic [SEL_W-1:0] SEL_R13  = 4'd13;
    localparam logic [SEL_W-1:0] SEL_R14  = 4'd14;
    localparam logic [SEL_W-1:0] SEL_ZERO = 4'd15;
    localparam logic [SEL_W-1:0] IDLE_SEL = SEL_ZERO;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two-bit encoding leaves spare codes that must fall back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_e;

    // Control word: per-ALU {sel1, sel2} pairs, then ops, enables, result_en, done_next
    localparam int CW_SEL_OFF  = 0;
    localparam int CW_OP_OFF   = CW_SEL_OFF + N_ALU * 2 * SEL_W;
    localparam int CW_EN_OFF   = CW_OP_OFF + N_ALU;
    localparam int CW_RES_OFF  = CW_EN_OFF + N_EN;
    localparam int CW_DONE_OFF = CW_RES_OFF + 1;
    localparam int CW_W        = CW_DONE_OFF + 1;

    // Enable bit positions inside the enable field
    localparam int EN_R2  = 0;
    localparam int EN_R5  = 1;
    localparam int EN_R6  = 2;
    localparam int EN_R9  = 3;
    localparam int EN_R12 = 4;
    localparam int EN_R13 = 5;
    localparam int EN_R14 = 6;

    typedef logic [CW_W-1:0] cw_t;

    // Word with every select parked on the zero input and everything else off
    function automatic cw_t cw_idle();
        cw_t cw;
        cw = '0;
        for (int k = 0; k < 2 * N_ALU; k++) begin
            cw[CW_SEL_OFF + k * SEL_W +: SEL_W] = IDLE_SEL;
        end
        return cw;
    endfunction

    // Program one ALU's operand selects and operation into a control word
    function automatic cw_t cw_alu(input cw_t cw_in, input int alu,
                                   input logic [SEL_W-1:0] s1,
                                   input logic [SEL_W-1:0] s2,
                                   input logic op);
        cw_t cw;
        cw = cw_in;
        cw[CW_SEL_OFF + alu * 2 * SEL_W +: SEL_W]           = s1;
        cw[CW_SEL_OFF + alu * 2 * SEL_W + SEL_W +: SEL_W]   = s2;
        cw[CW_OP_OFF + alu]                                  = op;
        return cw;
    endfunction

endpackage

// File: rtl/sched_ctrl_rom.sv
// rtl/sched_ctrl_rom.sv - combinational step to control-word decode for the 4-step add/sub schedule
module sched_ctrl_rom
    import sched_pkg::*;
(
    input  logic              valid_i,
    input  logic [STEP_W-1:0] step_i,
    output cw_t               cw_o
);

    // Decode the active step; anything not running yields the idle word
    always_comb begin
        cw_o = cw_idle();
        if (valid_i) begin
            case (step_i)
                2'd0: begin
                    cw_o = cw_alu(cw_o, 0, SEL_I1, SEL_I2, OP_ADD);
                    cw_o = cw_alu(cw_o, 1, SEL_I3, SEL_I4, OP_SUB);
                    cw_o = cw_alu(cw_o, 2, SEL_I5, SEL_I6, OP_ADD);
                    cw_o = cw_alu(cw_o, 3, SEL_I7, SEL_I8, OP_SUB);
                    cw_o[CW_EN_OFF + EN_R2]  = 1'b1;
                    cw_o[CW_EN_OFF + EN_R5]  = 1'b1;
                    cw_o[CW_EN_OFF + EN_R9]  = 1'b1;
                    cw_o[CW_EN_OFF + EN_R12] = 1'b1;
                end
                2'd1: begin
                    cw_o = cw_alu(cw_o, 0, SEL_R2, SEL_R5, OP_ADD);
                    cw_o = cw_alu(cw_o, 1, SEL_R9, SEL_R12, OP_ADD);
                    cw_o[CW_EN_OFF + EN_R6]  = 1'b1;
                    cw_o[CW_EN_OFF + EN_R13] = 1'b1;
                end
                2'd2: begin
                    cw_o = cw_alu(cw_o, 0, SEL_R6, SEL_R13, OP_SUB);
                    cw_o[CW_EN_OFF + EN_R14] = 1'b1;
                end
                default: begin
                    cw_o[CW_RES_OFF]  = 1'b1;
                    cw_o[CW_DONE_OFF] = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sched_controller.sv
// rtl/sched_controller.sv - control FSM sequencing the 4-ALU ((i1+i2)+(i3-i4))-((i5+i6)+(i7-i8)) schedule
module sched_controller
    import sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [SEL_W-1:0] alu1_sel1,
    output logic [SEL_W-1:0] alu1_sel2,
    output logic [SEL_W-1:0] alu2_sel1,
    output logic [SEL_W-1:0] alu2_sel2,
    output logic [SEL_W-1:0] alu3_sel1,
    output logic [SEL_W-1:0] alu3_sel2,
    output logic [SEL_W-1:0] alu4_sel1,
    output logic [SEL_W-1:0] alu4_sel2,
    output logic             alu1_op,
    output logic             alu2_op,
    output logic             alu3_op,
    output logic             alu4_op,
    output logic             reg_alu2_en,
    output logic             reg_alu5_en,
    output logic             reg_alu6_en,
    output logic             reg_alu9_en,
    output logic             reg_alu12_en,
    output logic             reg_alu13_en,
    output logic             reg_alu14_en,
    output logic             result_en,
    output logic             done_next
);

    localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    cw_t               cw;

    // Next state: walk S0..S3, relaunch from S3 on start, otherwise fall back to IDLE
    always_comb begin
        state_d = IDLE;
        step_d  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step_q != LAST_STEP) begin
                    state_d = RUN;
                    step_d  = step_q + 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State, step and busy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
        end
    end

    sched_ctrl_rom u_rom (
        .valid_i (state_q == RUN),
        .step_i  (step_q),
        .cw_o    (cw)
    );

    assign busy         = busy_q;
    assign alu1_sel1    = cw[CW_SEL_OFF + 0 * SEL_W +: SEL_W];
    assign alu1_sel2    = cw[CW_SEL_OFF + 1 * SEL_W +: SEL_W];
    assign alu2_sel1    = cw[CW_SEL_OFF + 2 * SEL_W +: SEL_W];
    assign alu2_sel2    = cw[CW_SEL_OFF + 3 * SEL_W +: SEL_W];
    assign alu3_sel1    = cw[CW_SEL_OFF + 4 * SEL_W +: SEL_W];
    assign alu3_sel2    = cw[CW_SEL_OFF + 5 * SEL_W +: SEL_W];
    assign alu4_sel1    = cw[CW_SEL_OFF + 6 * SEL_W +: SEL_W];
    assign alu4_sel2    = cw[CW_SEL_OFF + 7 * SEL_W +: SEL_W];
    assign alu1_op      = cw[CW_OP_OFF + 0];
    assign alu2_op      = cw[CW_OP_OFF + 1];
    assign alu3_op      = cw[CW_OP_OFF + 2];
    assign alu4_op      = cw[CW_OP_OFF + 3];
    assign reg_alu2_en  = cw[CW_EN_OFF + EN_R2];
    assign reg_alu5_en  = cw[CW_EN_OFF + EN_R5];
    assign reg_alu6_en  = cw[CW_EN_OFF + EN_R6];
    assign reg_alu9_en  = cw[CW_EN_OFF + EN_R9];
    assign reg_alu12_en = cw[CW_EN_OFF + EN_R12];
    assign reg_alu13_en = cw[CW_EN_OFF + EN_R13];
    assign reg_alu14_en = cw[CW_EN_OFF + EN_R14];
    assign result_en    = cw[CW_RES_OFF];
    assign done_next    = cw[CW_DONE_OFF];

endmodule

// File: tb/tb_sched_controller.sv
// tb/tb_sched_controller.sv - scoreboard bench for sched_controller driving a behavioural datapath
module tb_sched_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic [3:0] alu1_sel1, alu1_sel2, alu2_sel1, alu2_sel2;
    logic [3:0] alu3_sel1, alu3_sel2, alu4_sel1, alu4_sel2;
    logic alu1_op, alu2_op, alu3_op, alu4_op;
    logic reg_alu2_en, reg_alu5_en, reg_alu6_en, reg_alu9_en;
    logic reg_alu12_en, reg_alu13_en, reg_alu14_en;
    logic result_en, done_next;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sched_controller dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2),
        .alu2_sel1(alu2_sel1), .alu2_sel2(alu2_sel2),
        .alu3_sel1(alu3_sel1), .alu3_sel2(alu3_sel2),
        .alu4_sel1(alu4_sel1), .alu4_sel2(alu4_sel2),
        .alu1_op(alu1_op), .alu2_op(alu2_op), .alu3_op(alu3_op), .alu4_op(alu4_op),
        .reg_alu2_en(reg_alu2_en), .reg_alu5_en(reg_alu5_en), .reg_alu6_en(reg_alu6_en),
        .reg_alu9_en(reg_alu9_en), .reg_alu12_en(reg_alu12_en), .reg_alu13_en(reg_alu13_en),
        .reg_alu14_en(reg_alu14_en), .result_en(result_en), .done_next(done_next)
    );

    // Behavioural datapath sitting beside the controller
    logic [31:0] in_v [8];
    logic [31:0] r2, r5, r6, r9, r12, r13, r14, result;
    logic        done;

    function automatic logic [31:0] mux(input logic [3:0] s);
        case (s)
            4'd8:    return r2;
            4'd9:    return r5;
            4'd10:   return r6;
            4'd11:   return r9;
            4'd12:   return r12;
            4'd13:   return r13;
            4'd14:   return r14;
            4'd15:   return 32'd0;
            default: return in_v[s[2:0]];
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] a, input logic [3:0] b, input logic op);
        return op ? (mux(a) - mux(b)) : (mux(a) + mux(b));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r2 <= 0; r5 <= 0; r6 <= 0; r9 <= 0; r12 <= 0; r13 <= 0; r14 <= 0;
            result <= 0; done <= 1'b0;
        end else begin
            if (reg_alu2_en)  r2  <= alu(alu1_sel1, alu1_sel2, alu1_op);
            if (reg_alu5_en)  r5  <= alu(alu2_sel1, alu2_sel2, alu2_op);
            if (reg_alu9_en)  r9  <= alu(alu3_sel1, alu3_sel2, alu3_op);
            if (reg_alu12_en) r12 <= alu(alu4_sel1, alu4_sel2, alu4_op);
            if (reg_alu6_en)  r6  <= alu(alu1_sel1, alu1_sel2, alu1_op);
            if (reg_alu13_en) r13 <= alu(alu2_sel1, alu2_sel2, alu2_op);
            if (reg_alu14_en) r14 <= alu(alu1_sel1, alu1_sel2, alu1_op);
            if (result_en)    result <= r14;
            done <= done_next;
        end
    end

    // Reference model: a run accepted at edge a occupies edges a..a+3 and delivers at edge a+4
    typedef struct packed {
        int          due;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   last_a = -100;

    function automatic logic [31:0] ref_res();
        return ((in_v[0] + in_v[1]) + (in_v[2] - in_v[3])) - ((in_v[4] + in_v[5]) + (in_v[6] - in_v[7]));
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (!rst && start && edge_n >= last_a + 4) begin
            last_a = edge_n;
            sb.push_back('{due: edge_n + 4, res: ref_res()});
        end
    end

    // Expected {enables, result_en, done_next, alu1 sel1/sel2/op, alu4 sel1/sel2/op} for a run offset
    function automatic logic [26:0] exp_ctl(input int off);
        case (off)
            0:       return {7'b1101100, 2'b00, 4'd0,  4'd1,  1'b0, 4'd6,  4'd7,  1'b1};
            1:       return {7'b0010010, 2'b00, 4'd8,  4'd9,  1'b0, 4'd15, 4'd15, 1'b0};
            2:       return {7'b0000001, 2'b00, 4'd10, 4'd13, 1'b1, 4'd15, 4'd15, 1'b0};
            3:       return {7'b0000000, 2'b11, 4'd15, 4'd15, 1'b0, 4'd15, 4'd15, 1'b0};
            default: return {7'b0000000, 2'b00, 4'd15, 4'd15, 1'b0, 4'd15, 4'd15, 1'b0};
        endcase
    endfunction

    function automatic logic [26:0] act_ctl();
        return {reg_alu2_en, reg_alu5_en, reg_alu6_en, reg_alu9_en, reg_alu12_en, reg_alu13_en,
                reg_alu14_en, result_en, done_next, alu1_sel1, alu1_sel2, alu1_op,
                alu4_sel1, alu4_sel2, alu4_op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: control decode and busy every cycle, done/result popped from the scoreboard
    always @(negedge clk) begin
        int off;
        off = edge_n - last_a;
        check("busy", {31'd0, busy}, {31'd0, (off >= 0 && off <= 3)});
        check("ctl", {5'd0, act_ctl()}, {5'd0, exp_ctl(off)});
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            check("done_pulse", {31'd0, done}, 32'd1);
            check("result", result, sb[0].res);
            void'(sb.pop_front());
        end else begin
            check("no_done", {31'd0, done}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int a6, input int a7);
        in_v[0] = a0; in_v[1] = a1; in_v[2] = a2; in_v[3] = a3;
        in_v[4] = a4; in_v[5] = a5; in_v[6] = a6; in_v[7] = a7;
    endtask

    // Mid-cycle asynchronous reset; outputs must drop before the next edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        last_a = -100;
        sb.delete();
        #1;
        check("rst_async_ctl", {5'd0, act_ctl()}, {5'd0, exp_ctl(-1)});
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Single pulse run; reports cycles to done, busy cycles and the final result
    task automatic run_pulse(input int extra_at, output int done_k, output int busy_cnt,
                             output int done_cnt);
        done_k = -1; busy_cnt = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            start = (k == extra_at);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int dk, bc, dc, lows;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_ctl", {5'd0, act_ctl()}, {5'd0, exp_ctl(-1)});
        check("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single run with the reference operands
        set_in(10, 20, 7, 3, 1, 2, 9, 4);
        run_pulse(-1, dk, bc, dc);
        check("single_done_cycle", dk, 4);
        check("single_busy_cycles", bc, 4);
        check("single_done_count", dc, 1);
        check("single_result", result, 32'd26);

        // Subtraction wrap
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        run_pulse(-1, dk, bc, dc);
        check("wrap_result", result, 32'hFFFF_FFFF);
        check("wrap_done_count", dc, 1);

        // start pulsed while in S1 must not launch another run
        set_in(5, 6, 7, 8, 1, 1, 1, 1);
        run_pulse(1, dk, bc, dc);
        check("ignored_done_count", dc, 1);
        check("ignored_busy_cycles", bc, 4);
        check("ignored_idle", {31'd0, busy}, 32'd0);

        // Back-to-back with start held; operands change once S0 has been consumed
        set_in(3, 1, 4, 1, 5, 9, 2, 6);
        lows = 0;
        start = 1'b1;
        tick();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!busy) lows++;
                tick();
                if (c == 0) begin
                    for (int j = 0; j < 8; j++) in_v[j] = $urandom;
                end
            end
        end
        start = 1'b0;
        check("b2b_busy_drops", lows, 0);
        wait_idle();
        tick();

        // Abort during S2, then a clean run
        set_in(9, 9, 9, 9, 9, 9, 9, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        do_reset();
        repeat (6) tick();
        set_in(1, 2, 3, 4, 5, 6, 7, 8);
        run_pulse(-1, dk, bc, dc);
        check("abort_rerun_result", result, 32'hFFFF_FFF8);
        check("abort_rerun_done_cycle", dk, 4);

        // Randomized launches with random start lengths and gaps
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            for (int j = 0; j < 8; j++) in_v[j] = $urandom;
            start = 1'b1;
            repeat ($urandom_range(1, 7)) tick();
            start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            if (it == 20) do_reset();
        end
        wait_idle();
        repeat (6) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
